// File: rtl/chacha_block_sequencer.sv
// ChaCha20 keystream block sequencer: issues one core_start per block of a job and
// holds each finished block until downstream accepts it. Optional macro: CHACHA_CTR_WRAP_ERR_EN.
module chacha_block_sequencer #(
   parameter int unsigned B = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [31:0]   cfg_counter,
   input  logic [B-1:0]  cfg_nblocks,
   output logic          core_start,
   output logic [31:0]   core_counter,
   input  logic          core_done,
   output logic          ks_valid,
   input  logic          ks_ready,
   output logic          busy,
   output logic          job_done,
   output logic          wrap_err
);

   localparam int unsigned CTR_W = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CTR_W-1:0]   counter_q, counter_d;
   logic [B-1:0]       remaining_q, remaining_d;
   logic               ks_hs;

`ifdef CHACHA_CTR_WRAP_ERR_EN
   logic               wrap_err_q, wrap_err_d;
`endif

   assign ks_hs = (state_q == S_DRAIN) && ks_ready;

   // Next-state and job bookkeeping
   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      remaining_d = remaining_q;
`ifdef CHACHA_CTR_WRAP_ERR_EN
      wrap_err_d  = wrap_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
`ifdef CHACHA_CTR_WRAP_ERR_EN
               wrap_err_d = 1'b0;
`endif
               if (cfg_nblocks == B'(0)) begin
                  state_d = S_DONE;
               end else begin
                  counter_d   = cfg_counter;
                  remaining_d = cfg_nblocks;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (core_done) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (ks_hs) begin
               remaining_d = remaining_q - B'(1);
               counter_d   = counter_q + CTR_W'(1);
               state_d     = (remaining_q == B'(1)) ? S_DONE : S_ISSUE;
`ifdef CHACHA_CTR_WRAP_ERR_EN
               // A wrap with blocks still pending aborts the job instead of reusing a nonce/counter pair
               if ((counter_q == {CTR_W{1'b1}}) && (remaining_q > B'(1))) begin
                  wrap_err_d = 1'b1;
                  state_d    = S_DONE;
               end
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         counter_q   <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         remaining_q <= remaining_d;
      end
   end

`ifdef CHACHA_CTR_WRAP_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_err_q <= 1'b0;
      end else begin
         wrap_err_q <= wrap_err_d;
      end
   end
   assign wrap_err = wrap_err_q;
`else
   assign wrap_err = 1'b0;
`endif

   // Outputs decode directly from the state register
   assign cfg_ready    = (state_q == S_IDLE);
   assign core_start   = (state_q == S_ISSUE);
   assign ks_valid     = (state_q == S_DRAIN);
   assign busy         = (state_q != S_IDLE);
   assign job_done     = (state_q == S_DONE);
   assign core_counter = counter_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Directed bench for chacha_block_sequencer with a 4-cycle core model and a
// start/handshake monitor.
module tb_chacha_block_sequencer;

   localparam int unsigned B = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [31:0]   cfg_counter = '0;
   logic [B-1:0]  cfg_nblocks = '0;
   logic          core_start;
   logic [31:0]   core_counter;
   logic          core_done = 1'b0;
   logic          ks_valid;
   logic          ks_ready = 1'b1;
   logic          busy;
   logic          job_done;
   logic          wrap_err;

   int n_vec = 0;
   int n_err = 0;
   int hs = 0;
   int jd = 0;
   int cd_cnt = 0;
   logic [31:0] last_ctr = '0;
   logic prev_kv = 1'b0;
   logic prev_hs = 1'b0;
   logic [31:0] sq[$];

   chacha_block_sequencer #(.B(B)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_counter(cfg_counter), .cfg_nblocks(cfg_nblocks),
      .core_start(core_start), .core_counter(core_counter), .core_done(core_done),
      .ks_valid(ks_valid), .ks_ready(ks_ready),
      .busy(busy), .job_done(job_done), .wrap_err(wrap_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Core model (done 4 cycles after start) plus start/handshake/job_done monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         cd_cnt = 0;
         core_done = 1'b0;
         prev_kv = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (cd_cnt > 0) begin
            cd_cnt = cd_cnt - 1;
            core_done = (cd_cnt == 0);
         end else begin
            core_done = 1'b0;
         end
         if (core_start) begin
            sq.push_back(core_counter);
            last_ctr = core_counter;
            cd_cnt = 4;
         end
         if (ks_valid && ks_ready) begin
            hs++;
            chk("ctr_stable", core_counter, last_ctr);
         end
         if (prev_kv && !prev_hs) chk("kv_hold", 32'(ks_valid), 32'd1);
         prev_kv = ks_valid;
         prev_hs = ks_valid && ks_ready;
         if (job_done) jd++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [31:0] ctr, input logic [B-1:0] n);
      sq = {};
      cfg_counter = ctr;
      cfg_nblocks = n;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      if (n != B'(0)) chk("start_lat", 32'(core_start), 32'd1);
   endtask

   task automatic wait_jd(input int target, input string tag);
      int i;
      i = 0;
      while (jd < target && i < 300) begin
         tick();
         i++;
      end
      chk(tag, 32'(jd), 32'(target));
   endtask

   task automatic run_job(input logic [31:0] ctr, input logic [B-1:0] n);
      int j0;
      j0 = jd;
      accept(ctr, n);
      wait_jd(j0 + 1, "job_timeout");
      tick();
      tick();
   endtask

   initial begin
      int j0, h0, i;
      // Reset and idle
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_core_start", 32'(core_start), 32'd0);
      chk("rst_ks_valid", 32'(ks_valid), 32'd0);
      chk("rst_core_counter", core_counter, 32'd0);
      chk("rst_job_done", 32'(job_done), 32'd0);
      chk("rst_wrap_err", 32'(wrap_err), 32'd0);

      // Basic 3-block job
      h0 = hs;
      j0 = jd;
      run_job(32'd1, 4'd3);
      chk("j1_starts", 32'(sq.size()), 32'd3);
      if (sq.size() == 3) begin
         chk("j1_ctr0", sq[0], 32'd1);
         chk("j1_ctr1", sq[1], 32'd2);
         chk("j1_ctr2", sq[2], 32'd3);
      end
      chk("j1_hs", 32'(hs - h0), 32'd3);
      chk("j1_jd", 32'(jd - j0), 32'd1);
      chk("j1_busy", 32'(busy), 32'd0);
      chk("j1_cfg_ready", 32'(cfg_ready), 32'd1);

      // Same job with downstream stalled for 6 cycles on block 2
      h0 = hs;
      j0 = jd;
      accept(32'd1, 4'd3);
      i = 0;
      while (hs < h0 + 1 && i < 100) begin tick(); i++; end
      chk("st_hs1", 32'(hs - h0), 32'd1);
      ks_ready = 1'b0;
      i = 0;
      while (!ks_valid && i < 100) begin tick(); i++; end
      chk("st_kv_up", 32'(ks_valid), 32'd1);
      repeat (6) begin
         tick();
         chk("st_kv", 32'(ks_valid), 32'd1);
         chk("st_ctr", core_counter, 32'd2);
         chk("st_starts", 32'(sq.size()), 32'd2);
      end
      ks_ready = 1'b1;
      tick();
      chk("st_restart", 32'(core_start), 32'd1);
      chk("st_ctr3", core_counter, 32'd3);
      wait_jd(j0 + 1, "st_timeout");
      tick();
      tick();
      chk("st_starts_tot", 32'(sq.size()), 32'd3);
      chk("st_hs_tot", 32'(hs - h0), 32'd3);

      // Zero-length job
      j0 = jd;
      run_job(32'h55, 4'd0);
      chk("z_starts", 32'(sq.size()), 32'd0);
      chk("z_jd", 32'(jd - j0), 32'd1);

      // Counter wrap
      run_job(32'hFFFF_FFFE, 4'd3);
`ifdef CHACHA_CTR_WRAP_ERR_EN
      chk("w_starts", 32'(sq.size()), 32'd2);
      if (sq.size() == 2) begin
         chk("w_ctr0", sq[0], 32'hFFFF_FFFE);
         chk("w_ctr1", sq[1], 32'hFFFF_FFFF);
      end
      chk("w_err", 32'(wrap_err), 32'd1);
`else
      chk("w_starts", 32'(sq.size()), 32'd3);
      if (sq.size() == 3) begin
         chk("w_ctr0", sq[0], 32'hFFFF_FFFE);
         chk("w_ctr1", sq[1], 32'hFFFF_FFFF);
         chk("w_ctr2", sq[2], 32'h0000_0000);
      end
      chk("w_err", 32'(wrap_err), 32'd0);
`endif
      run_job(32'd5, 4'd1);
      chk("w_clr", 32'(wrap_err), 32'd0);
      chk("w_next_ctr", (sq.size() == 1) ? sq[0] : 32'hDEAD_BEEF, 32'd5);

      // Reset during WAIT of block 2 of 4
      j0 = jd;
      accept(32'd10, 4'd4);
      i = 0;
      while (sq.size() < 2 && i < 100) begin tick(); i++; end
      chk("r_starts", 32'(sq.size()), 32'd2);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("r_busy", 32'(busy), 32'd0);
      chk("r_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("r_ks_valid", 32'(ks_valid), 32'd0);
      chk("r_core_start", 32'(core_start), 32'd0);
      chk("r_core_counter", core_counter, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("r_no_jd", 32'(jd - j0), 32'd0);
      j0 = jd;
      run_job(32'd7, 4'd1);
      chk("r_new_starts", 32'(sq.size()), 32'd1);
      chk("r_new_ctr", (sq.size() == 1) ? sq[0] : 32'hDEAD_BEEF, 32'd7);
      chk("r_new_jd", 32'(jd - j0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
